// File: rtl/xillybus_udiv_pkg.sv
// Shared definitions for the iterative unsigned divider: FSM state
// encoding, default operand widths and the bit-counter width helper.
package xillybus_udiv_pkg;

  localparam int UDIV_DEF_N = 30;  // dividend / quotient width
  localparam int UDIV_DEF_M = 15;  // divisor / remainder width

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } udiv_state_e;

  // Counter must hold N-1; keep at least one bit for degenerate widths.
  function automatic int udiv_cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int UDIV_DEF_CNT_W = udiv_cnt_w(UDIV_DEF_N);

endpackage

// File: rtl/xillybus_udiv_step.sv
// One restoring-division step: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor, keep or restore.
module xillybus_udiv_step
  import xillybus_udiv_pkg::*;
#(
  parameter int M = UDIV_DEF_M
) (
  input  logic [M:0]   r,
  input  logic         dvd_bit,
  input  logic [M-1:0] divisor,
  output logic [M:0]   r_next,
  output logic         qbit
);

  // r[M] is always 0 between steps (r < divisor), so comparing the full
  // shifted value is the same as comparing {r[M-1:0], dvd_bit}.
  logic [M+1:0] shifted;
  logic [M:0]   sub_val;

  assign shifted = {r, dvd_bit};

  // Trial compare against the zero-extended divisor; subtract only on success.
  always_comb begin
    qbit    = (shifted >= {2'b00, divisor});
    sub_val = qbit ? {1'b0, divisor} : '0;
    r_next  = shifted[M:0] - sub_val;
  end

endmodule

// File: rtl/xillybus_wrapper_udiv_seq.sv
// Iterative unsigned restoring divider, one quotient bit per clock,
// with the ap_start/ap_ready/ap_done/ap_idle block-level handshake.
// Optional macro UDIV_DBZ_FAST_EN: adds the dbz port and finishes a
// divide-by-zero in one cycle instead of running all N steps.
//
// Handshake: an operation is accepted on the rising edge where
// ap_ready is high; ap_ready = ap_start while the FSM is IDLE or DONE,
// so a caller holding ap_start through DONE gets back-to-back ops with
// no idle bubble. ap_start in CALC is ignored. ap_done is a single
// cycle pulse; quot/rem hold from then until the next op completes.
module xillybus_wrapper_udiv_seq
  import xillybus_udiv_pkg::*;
#(
  parameter int DIVIDEND_WIDTH = UDIV_DEF_N,
  parameter int DIVISOR_WIDTH  = UDIV_DEF_M
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst_n,
  input  logic                      ap_start,
  output logic                      ap_ready,
  output logic                      ap_idle,
  output logic                      ap_done,
  input  logic [DIVIDEND_WIDTH-1:0] din0,
  input  logic [DIVISOR_WIDTH-1:0]  din1,
  output logic [DIVIDEND_WIDTH-1:0] quot,
  output logic [DIVISOR_WIDTH-1:0]  rem
`ifdef UDIV_DBZ_FAST_EN
  ,
  output logic                      dbz
`endif
);

  localparam int N     = DIVIDEND_WIDTH;
  localparam int M     = DIVISOR_WIDTH;
  localparam int CNT_W = udiv_cnt_w(N);

  udiv_state_e      state;
  logic [CNT_W-1:0] cnt;
  // Dividend bits leave from the MSB while quotient bits enter at the LSB,
  // so after N steps this register holds the quotient.
  logic [N-1:0]     work;
  logic [M-1:0]     divisor_q;
  logic [M:0]       r;
  logic [M:0]       r_next;
  logic             qbit;

  xillybus_udiv_step #(.M(M)) u_step (
    .r       (r),
    .dvd_bit (work[N-1]),
    .divisor (divisor_q),
    .r_next  (r_next),
    .qbit    (qbit)
  );

  // Operand capture happens on the edge where this is high.
  assign ap_ready = ap_start & ((state == ST_IDLE) | (state == ST_DONE));

  // Control FSM with registered handshake outputs and result registers.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      work      <= '0;
      divisor_q <= '0;
      r         <= '0;
      quot      <= '0;
      rem       <= '0;
      ap_idle   <= 1'b1;
      ap_done   <= 1'b0;
`ifdef UDIV_DBZ_FAST_EN
      dbz       <= 1'b0;
`endif
    end else begin
      ap_done <= 1'b0;
      unique case (state)
        ST_IDLE, ST_DONE: begin
          if (ap_start) begin
            work      <= din0;
            divisor_q <= din1;
            r         <= '0;
            cnt       <= CNT_W'(N - 1);
            state     <= ST_CALC;
            ap_idle   <= 1'b0;
`ifdef UDIV_DBZ_FAST_EN
            dbz       <= 1'b0;
            // Zero divisor: the full run would give all ones and the low
            // dividend bits anyway, so publish that immediately.
            if (din1 == '0) begin
              state   <= ST_DONE;
              ap_done <= 1'b1;
              quot    <= '1;
              rem     <= din0[M-1:0];
              dbz     <= 1'b1;
            end
`endif
          end else if (state == ST_DONE) begin
            state   <= ST_IDLE;
            ap_idle <= 1'b1;
          end
        end
        ST_CALC: begin
          work <= {work[N-2:0], qbit};
          r    <= r_next;
          if (cnt == '0) begin
            state   <= ST_DONE;
            ap_done <= 1'b1;
            quot    <= {work[N-2:0], qbit};
            rem     <= r_next[M-1:0];
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state   <= ST_IDLE;
          ap_idle <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xillybus_wrapper_udiv_seq.sv
// Bench for xillybus_wrapper_udiv_seq: directed operations with literal
// expected results, plus a cycle-by-cycle compare against an arithmetic
// model of the handshake and results (quotient = a/b, remainder = a%b).
module tb_xillybus_wrapper_udiv_seq;

  localparam int N = 30;
  localparam int M = 15;
`ifdef UDIV_DBZ_FAST_EN
  localparam bit FAST_DBZ = 1'b1;
`else
  localparam bit FAST_DBZ = 1'b0;
`endif

  logic         ap_clk = 1'b0;
  logic         ap_rst_n;
  logic         ap_start;
  logic         ap_ready;
  logic         ap_idle;
  logic         ap_done;
  logic [N-1:0] din0;
  logic [M-1:0] din1;
  logic [N-1:0] quot;
  logic [M-1:0] rem;
`ifdef UDIV_DBZ_FAST_EN
  logic         dbz;
`endif

  xillybus_wrapper_udiv_seq #(
    .DIVIDEND_WIDTH(N),
    .DIVISOR_WIDTH (M)
  ) dut (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .ap_start (ap_start),
    .ap_ready (ap_ready),
    .ap_idle  (ap_idle),
    .ap_done  (ap_done),
    .din0     (din0),
    .din1     (din1),
    .quot     (quot),
    .rem      (rem)
`ifdef UDIV_DBZ_FAST_EN
    ,
    .dbz      (dbz)
`endif
  );

  // ---------------- clock / cycle counter ----------------
  always #5 ap_clk = ~ap_clk;

  int cyc = 0;
  always @(posedge ap_clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_bad = 0;
  int ready_cnt = 0;

  logic [N-1:0] exp_q[$];      // expected quotients, oldest first
  logic [M-1:0] exp_r_q[$];    // expected remainders
  int           exp_cyc_q[$];  // cycle at which ap_done must be seen
  logic [N-1:0] held_quot = '0;
  logic [M-1:0] held_rem  = '0;
  logic         held_dbz  = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Model of one accepted operation, from plain arithmetic.
  task automatic model_push(input logic [N-1:0] a, input logic [M-1:0] b);
    logic [N-1:0] q;
    logic [M-1:0] rr;
    int lat;
    if (b == '0) begin
      q  = '1;
      rr = a[M-1:0];
    end else begin
      q  = a / N'(b);
      rr = M'(a % N'(b));
    end
    lat = (FAST_DBZ && b == '0) ? 1 : N;
    exp_q.push_back(q);
    exp_r_q.push_back(rr);
    exp_cyc_q.push_back(cyc + 1 + lat);
    held_dbz = FAST_DBZ && (b == '0);
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_r_q.delete();
    exp_cyc_q.delete();
    held_quot = '0;
    held_rem  = '0;
    held_dbz  = 1'b0;
  endtask

  // ---------------- per-cycle compare ----------------
  logic m_idle, m_done, m_ready;
  always @(negedge ap_clk) begin
    m_idle  = (exp_cyc_q.size() == 0);
    m_done  = !m_idle && (exp_cyc_q[0] == cyc);
    m_ready = ap_start && (m_idle || m_done);
    if (ap_ready) ready_cnt++;
    check("ap_ready", 64'(ap_ready), 64'(m_ready));
    check("ap_idle",  64'(ap_idle),  64'(m_idle));
    check("ap_done",  64'(ap_done),  64'(m_done));
    if (m_done) begin
      held_quot = exp_q.pop_front();
      held_rem  = exp_r_q.pop_front();
      void'(exp_cyc_q.pop_front());
    end
    check("quot", 64'(quot), 64'(held_quot));
    check("rem",  64'(rem),  64'(held_rem));
`ifdef UDIV_DBZ_FAST_EN
    check("dbz",  64'(dbz),  64'(held_dbz));
`endif
    if (m_ready) model_push(din0, din1);
  end

  // ---------------- driver tasks ----------------
  task automatic wait_done(output int done_cyc);
    bit seen = 1'b0;
    done_cyc = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge ap_clk);
      if (ap_done) begin
        seen = 1'b1;
        done_cyc = cyc;
        break;
      end
    end
    check("done_seen", 64'(seen), 64'd1);
  endtask

  task automatic run_op(input logic [N-1:0] a, input logic [M-1:0] b,
                        input logic [N-1:0] eq, input logic [M-1:0] er, input int lat);
    int cap_cyc, done_cyc, r0;
    r0 = ready_cnt;
    @(posedge ap_clk);
    #1;
    ap_start = 1'b1;
    din0 = a;
    din1 = b;
    @(posedge ap_clk);
    #1;
    cap_cyc  = cyc;
    ap_start = 1'b0;
    din0 = N'($urandom);
    din1 = M'($urandom);
    wait_done(done_cyc);
    check("lit_quot", 64'(quot), 64'(eq));
    check("lit_rem",  64'(rem),  64'(er));
    check("latency",  64'(done_cyc - cap_cyc), 64'(lat));
    check("ready_pulses", 64'(ready_cnt - r0), 64'd1);
`ifdef UDIV_DBZ_FAST_EN
    check("lit_dbz", 64'(dbz), 64'(b == '0));
`endif
  endtask

  // ---------------- directed vectors ----------------
  localparam int NV = 6;
  logic [N-1:0] va [NV] = '{30'd1000000, 30'h3FFFFFFF, 30'h3FFFFFFF, 30'd5, 30'd0, 30'h12345};
  logic [M-1:0] vb [NV] = '{15'd1234, 15'h7FFF, 15'd1, 15'd7, 15'd9, 15'd0};
  logic [N-1:0] vq [NV] = '{30'd810, 30'd32769, 30'h3FFFFFFF, 30'd0, 30'd0, 30'h3FFFFFFF};
  logic [M-1:0] vr [NV] = '{15'd460, 15'd0, 15'd0, 15'd5, 15'd0, 15'h2345};

  initial begin
    int d1, d2, lat;
    ap_rst_n = 1'b0;
    ap_start = 1'b0;
    din0 = '0;
    din1 = '0;
    repeat (3) @(posedge ap_clk);
    #1;
    check("rst_quot", 64'(quot), 64'd0);
    check("rst_rem",  64'(rem),  64'd0);
    check("rst_idle", 64'(ap_idle), 64'd1);
    check("rst_done", 64'(ap_done), 64'd0);
    @(posedge ap_clk);
    #2;
    ap_rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      lat = (FAST_DBZ && vb[i] == '0) ? 1 : N;
      run_op(va[i], vb[i], vq[i], vr[i], lat);
    end

    // Back-to-back: ap_start held high through the first op's DONE cycle.
    @(posedge ap_clk);
    #1;
    ap_start = 1'b1;
    din0 = 30'd1000;
    din1 = 15'd3;
    @(posedge ap_clk);
    #1;
    din0 = 30'd100;
    din1 = 15'd7;
    wait_done(d1);
    check("b2b_quot1", 64'(quot), 64'd333);
    check("b2b_rem1",  64'(rem),  64'd1);
    @(posedge ap_clk);
    #1;
    ap_start = 1'b0;
    wait_done(d2);
    check("b2b_quot2", 64'(quot), 64'd14);
    check("b2b_rem2",  64'(rem),  64'd2);
    check("b2b_spacing", 64'(d2 - d1), 64'd31);

    // ap_start pulse in the middle of CALC must be ignored.
    @(posedge ap_clk);
    #1;
    ap_start = 1'b1;
    din0 = 30'd100;
    din1 = 15'd7;
    @(posedge ap_clk);
    #1;
    ap_start = 1'b0;
    repeat (5) @(posedge ap_clk);
    #1;
    ap_start = 1'b1;
    din0 = 30'd999;
    din1 = 15'd3;
    @(posedge ap_clk);
    #1;
    ap_start = 1'b0;
    wait_done(d1);
    check("midcalc_quot", 64'(quot), 64'd14);
    check("midcalc_rem",  64'(rem),  64'd2);

    // Reset asserted 12 cycles into an op: outputs clear, no ap_done.
    @(posedge ap_clk);
    #1;
    ap_start = 1'b1;
    din0 = 30'd1000000;
    din1 = 15'd1234;
    @(posedge ap_clk);
    #1;
    ap_start = 1'b0;
    repeat (11) @(posedge ap_clk);
    #2;
    ap_rst_n = 1'b0;
    model_reset();
    #1;
    check("abort_quot", 64'(quot), 64'd0);
    check("abort_rem",  64'(rem),  64'd0);
    check("abort_idle", 64'(ap_idle), 64'd1);
    check("abort_done", 64'(ap_done), 64'd0);
    repeat (2) @(posedge ap_clk);
    #2;
    ap_rst_n = 1'b1;
    repeat (35) @(negedge ap_clk);
    run_op(30'd5, 15'd7, 30'd0, 15'd5, N);
    run_op(30'd1000000, 15'd1234, 30'd810, 15'd460, N);

    repeat (3) @(negedge ap_clk);
    check("queue_drained", 64'(exp_cyc_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
